// File: rtl/shr8_share_arb_pkg.sv
// rtl/shr8_share_arb_pkg.sv - shared widths, mode encodings and output register states
package shr8_share_arb_pkg;

  localparam int SHR_W     = 8;
  localparam int SHR_AMT_W = 3;

  localparam logic SHR_LOGICAL = 1'b0;
  localparam logic SHR_ROTATE  = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_t;

endpackage

// File: rtl/shr8_core.sv
// rtl/shr8_core.sv - combinational 8-bit right shifter/rotator, log stages 4,2,1
module shr8_core
  import shr8_share_arb_pkg::*;
(
  input  logic [SHR_W-1:0]     data,
  input  logic [SHR_AMT_W-1:0] amt,
  input  logic                 rot,
  output logic [SHR_W-1:0]     result
);

  logic [SHR_W-1:0] s4;
  logic [SHR_W-1:0] s2;
  logic [SHR_W-1:0] s1;
  logic             is_rot;

  assign is_rot = (rot == SHR_ROTATE);

  // Each stage either wraps the low bits around or fills them with zero.
  always_comb begin
    s4 = data;
    if (amt[2]) s4 = is_rot ? {data[3:0], data[7:4]} : {4'b0, data[7:4]};
    s2 = s4;
    if (amt[1]) s2 = is_rot ? {s4[1:0], s4[7:2]} : {2'b0, s4[7:2]};
    s1 = s2;
    if (amt[0]) s1 = is_rot ? {s2[0], s2[7:1]} : {1'b0, s2[7:1]};
  end

  assign result = s1;

endmodule

// File: rtl/shr8_share_arb.sv
// rtl/shr8_share_arb.sv - round-robin share of one 8-bit shifter among NREQ requesters
module shr8_share_arb
  import shr8_share_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*SHR_W-1:0]     req_data,
  input  logic [NREQ*SHR_AMT_W-1:0] req_amt,
  input  logic [NREQ-1:0]           req_rot,
  output logic [NREQ-1:0]           req_ready,
  output logic                      resp_valid,
  output logic [SHR_W-1:0]          resp_data,
  output logic [ID_W-1:0]           resp_id,
  input  logic                      resp_ready,
  output logic [15:0]               busy_cnt
);

  out_state_t           state;
  logic [ID_W-1:0]      rr_ptr;
  logic [ID_W-1:0]      win;
  logic [ID_W-1:0]      cand;
  logic                 found;
  logic                 accept;
  logic                 xfer;
  logic [SHR_W-1:0]     sel_data;
  logic [SHR_AMT_W-1:0] sel_amt;
  logic                 sel_rot;
  logic [SHR_W-1:0]     shifted;

  assign accept = (state == ST_EMPTY) | resp_ready;

  // Search starts just past the last winner so every requester gets a turn.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = ID_W'((int'(rr_ptr) + i) % NREQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign xfer = found & accept & ~rst;

  always_comb begin
    req_ready = '0;
    if (xfer) req_ready[win] = 1'b1;
  end

  always_comb begin
    sel_data = '0;
    sel_amt  = '0;
    sel_rot  = SHR_LOGICAL;
    for (int n = 0; n < NREQ; n++) begin
      if (ID_W'(n) == win) begin
        sel_data = req_data[n*SHR_W +: SHR_W];
        sel_amt  = req_amt[n*SHR_AMT_W +: SHR_AMT_W];
        sel_rot  = req_rot[n];
      end
    end
  end

  shr8_core u_core (
    .data   (sel_data),
    .amt    (sel_amt),
    .rot    (sel_rot),
    .result (shifted)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_EMPTY;
      resp_data <= '0;
      resp_id   <= '0;
      rr_ptr    <= ID_W'(NREQ - 1);
      busy_cnt  <= '0;
    end else begin
      case (state)
        ST_EMPTY: if (xfer) state <= ST_FULL;
        ST_FULL:  if (resp_ready && !xfer) state <= ST_EMPTY;
        default:  state <= ST_EMPTY;
      endcase
      if (xfer) begin
        resp_data <= shifted;
        resp_id   <= win;
        rr_ptr    <= win;
      end
      if ((|req_valid) && !xfer && (busy_cnt != 16'hFFFF)) busy_cnt <= busy_cnt + 16'd1;
    end
  end

  assign resp_valid = (state == ST_FULL);

endmodule

// File: tb/tb_shr8_share_arb.sv
// tb/tb_shr8_share_arb.sv - randomized and directed checks against a behavioural model
module tb_shr8_share_arb;

  localparam int NREQ = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [NREQ-1:0] req_valid;
  logic [NREQ*8-1:0] req_data;
  logic [NREQ*3-1:0] req_amt;
  logic [NREQ-1:0] req_rot;
  logic [NREQ-1:0] req_ready;
  logic            resp_valid;
  logic [7:0]      resp_data;
  logic [1:0]      resp_id;
  logic            resp_ready;
  logic [15:0]     busy_cnt;

  int checks = 0;
  int errors = 0;

  // model state
  int       m_ptr;
  bit       m_full;
  bit [7:0] m_data;
  int       m_id;
  int       m_busy;
  int       m_xfer_id;

  shr8_share_arb #(.NREQ(NREQ), .ID_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_amt    (req_amt),
    .req_rot    (req_rot),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .resp_ready (resp_ready),
    .busy_cnt   (busy_cnt)
  );

  always #5 clk = ~clk;

  function automatic bit [7:0] ref_shift(input bit [7:0] d, input int a, input bit r);
    bit [15:0] dd;
    dd = {d, d};
    if (r) return 8'((dd >> a) & 16'h00FF);
    return d >> a;
  endfunction

  function automatic int model_win();
    for (int i = 1; i <= NREQ; i++) begin
      if (req_valid[(m_ptr + i) % NREQ]) return (m_ptr + i) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] model_ready();
    int w;
    w = model_win();
    if (rst || w < 0 || !(!m_full || resp_ready)) return '0;
    return NREQ'(1) << w;
  endfunction

  task automatic set_req(input int n, input bit v, input bit [7:0] d, input int a, input bit r);
    req_valid[n]       = v;
    req_data[n*8 +: 8] = d;
    req_amt[n*3 +: 3]  = 3'(a);
    req_rot[n]         = r;
  endtask

  task automatic tick();
    int w;
    bit x;
    bit [7:0] nd;
    w  = model_win();
    x  = !rst && (w >= 0) && (!m_full || resp_ready);
    nd = (w >= 0) ? ref_shift(req_data[w*8 +: 8], int'(req_amt[w*3 +: 3]), req_rot[w]) : 8'h00;
    @(posedge clk);
    m_xfer_id = x ? w : -1;
    if (rst) begin
      m_full = 0; m_data = 0; m_id = 0; m_busy = 0; m_ptr = NREQ - 1;
    end else begin
      if (req_valid != 0 && !x && m_busy < 65535) m_busy++;
      if (x) begin
        m_full = 1; m_data = nd; m_id = w; m_ptr = w;
      end else if (resp_ready) begin
        m_full = 0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '1; req_data = '1; req_amt = '0; req_rot = '0; resp_ready = 1'b1;
    tick();
    tick();
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
    checks++;
    if (resp_valid !== 1'b0 || resp_data !== 8'h00 || resp_id !== 2'd0 || busy_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_state: got v=%b d=%h id=%0d busy=%0d expected v=0 d=00 id=0 busy=0",
               resp_valid, resp_data, resp_id, busy_cnt);
    end
    req_valid = '0;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_single();
    do_reset();
    resp_ready = 1'b1;
    set_req(0, 1, 8'b00111111, 2, 0);
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready: got %b expected 0001", req_ready); end
    tick();
    req_valid = '0;
    #1;
    checks++;
    if (resp_valid !== 1'b1 || resp_data !== 8'b00001111 || resp_id !== 2'd0) begin
      errors++;
      $display("FAIL single_resp: got v=%b d=%b id=%0d expected v=1 d=00001111 id=0", resp_valid, resp_data, resp_id);
    end
  endtask

  task automatic test_rotate();
    bit [7:0] din [3]  = '{8'b01100000, 8'b01000011, 8'b00001100};
    int       amt [3]  = '{4, 1, 6};
    bit [7:0] dexp [3] = '{8'b00000110, 8'b10100001, 8'b00110000};
    resp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_valid = '0;
      set_req(2, 1, din[i], amt[i], 1);
      #1;
      tick();
      req_valid = '0;
      #1;
      checks++;
      if (resp_valid !== 1'b1 || resp_data !== dexp[i] || resp_id !== 2'd2) begin
        errors++;
        $display("FAIL rotate_%0d: got v=%b d=%b id=%0d expected v=1 d=%b id=2", i, resp_valid, resp_data, resp_id, dexp[i]);
      end
    end
  endtask

  task automatic test_fairness();
    int exp_id [6] = '{0, 1, 2, 3, 0, 1};
    int rdy_cnt [NREQ];
    do_reset();
    resp_ready = 1'b1;
    for (int n = 0; n < NREQ; n++) begin
      set_req(n, 1, 8'(8'h11 * (n + 1)), n, n[0]);
      rdy_cnt[n] = 0;
    end
    for (int c = 0; c < 6; c++) begin
      #1;
      if (c < 4) for (int n = 0; n < NREQ; n++) if (req_ready[n]) rdy_cnt[n]++;
      tick();
      checks++;
      if (resp_valid !== 1'b1 || int'(resp_id) != exp_id[c]) begin
        errors++;
        $display("FAIL fair_seq_%0d: got v=%b id=%0d expected v=1 id=%0d", c, resp_valid, resp_id, exp_id[c]);
      end
    end
    for (int n = 0; n < NREQ; n++) begin
      checks++;
      if (rdy_cnt[n] != 1) begin errors++; $display("FAIL fair_ready_%0d: got %0d grants expected 1", n, rdy_cnt[n]); end
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    int b0;
    bit [7:0] held;
    do_reset();
    resp_ready = 1'b1;
    set_req(1, 1, 8'hA5, 3, 0);
    #1;
    tick();
    held = ref_shift(8'hA5, 3, 0);
    resp_ready = 1'b0;
    set_req(1, 1, 8'h3C, 5, 1);
    b0 = m_busy;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (req_ready !== 4'b0000 || resp_data !== held || resp_id !== 2'd1 || resp_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold_%0d: got rdy=%b d=%h id=%0d v=%b expected rdy=0000 d=%h id=1 v=1",
                 c, req_ready, resp_data, resp_id, resp_valid, held);
      end
      tick();
    end
    checks++;
    if (int'(busy_cnt) != b0 + 3) begin errors++; $display("FAIL bp_busy: got %0d expected %0d", busy_cnt, b0 + 3); end
    resp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_release_ready: got %b expected 0010", req_ready); end
    tick();
    req_valid = '0;
    #1;
    checks++;
    if (resp_valid !== 1'b1 || resp_data !== ref_shift(8'h3C, 5, 1) || resp_id !== 2'd1) begin
      errors++;
      $display("FAIL bp_refill: got v=%b d=%h id=%0d expected v=1 d=%h id=1", resp_valid, resp_data, resp_id, ref_shift(8'h3C, 5, 1));
    end
  endtask

  task automatic test_reset_mid();
    resp_ready = 1'b0;
    set_req(2, 1, 8'hF0, 1, 0);
    set_req(3, 1, 8'h0F, 2, 1);
    #1;
    tick();
    tick();
    rst = 1'b1;
    tick();
    #1;
    checks++;
    if (resp_valid !== 1'b0 || busy_cnt !== 16'd0 || req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL rst_mid: got v=%b busy=%0d rdy=%b expected v=0 busy=0 rdy=0000", resp_valid, busy_cnt, req_ready);
    end
    rst = 1'b0;
    req_valid = '0;
    set_req(0, 1, 8'h81, 7, 1);
    set_req(3, 1, 8'h42, 0, 0);
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL rst_mid_prio: got %b expected 0001", req_ready); end
    tick();
    req_valid = '0;
  endtask

  task automatic test_random();
    logic [NREQ-1:0] er;
    do_reset();
    req_valid = '0;
    for (int c = 0; c < 400; c++) begin
      for (int n = 0; n < NREQ; n++) begin
        if (m_xfer_id == n) req_valid[n] = 1'b0;
        if (!req_valid[n] && $urandom_range(0, 1) == 1)
          set_req(n, 1, 8'($urandom), int'($urandom_range(0, 7)), 1'($urandom));
      end
      resp_ready = ($urandom_range(0, 3) != 0);
      #1;
      er = model_ready();
      checks++;
      if (req_ready !== er) begin errors++; $display("FAIL rand_ready_%0d: got %b expected %b", c, req_ready, er); end
      tick();
      checks++;
      if (resp_valid !== m_full || int'(busy_cnt) != m_busy || (m_full && (resp_data !== m_data || int'(resp_id) != m_id))) begin
        errors++;
        $display("FAIL rand_out_%0d: got v=%b d=%h id=%0d busy=%0d expected v=%b d=%h id=%0d busy=%0d",
                 c, resp_valid, resp_data, resp_id, busy_cnt, m_full, m_data, m_id, m_busy);
      end
    end
    req_valid = '0;
  endtask

  task automatic test_saturation();
    do_reset();
    resp_ready = 1'b1;
    set_req(0, 1, 8'h77, 1, 0);
    #1;
    tick();
    resp_ready = 1'b0;
    for (int i = 0; i < 70000; i++) begin
      tick();
      if (i == 65533) begin
        checks++;
        if (busy_cnt !== 16'hFFFE) begin errors++; $display("FAIL sat_pre: got %h expected fffe", busy_cnt); end
      end
    end
    checks++;
    if (busy_cnt !== 16'hFFFF || int'(busy_cnt) != m_busy) begin
      errors++;
      $display("FAIL sat_hold: got %h expected ffff", busy_cnt);
    end
    req_valid = '0;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0; req_data = '0; req_amt = '0; req_rot = '0; resp_ready = 1'b0;
    m_ptr = NREQ - 1; m_full = 0; m_data = 0; m_id = 0; m_busy = 0; m_xfer_id = -1;
    #2;
    test_reset();
    test_single();
    test_rotate();
    test_fairness();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shr8_share_arb.md
Name: shr8_share_arb

Overview:
- Shares one 8-bit right barrel shifter between NREQ independent requesters.
- Each requester offers an operand, a shift amount and a rotate/logical select over a valid/ready handshake.
- A round-robin arbiter grants one request per cycle and drives the shifter. The result is held in a one-entry output register, tagged with the requester id, until the downstream consumer accepts it.
- Sits between the functional units that issue shifts and the common shift datapath.

Parameters:
NREQ, 4, number of requesters (2..8)
ID_W, 2, requester id width, equals clog2(NREQ)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
req_valid  input  NREQ  per-requester request valid
req_data  input  NREQ*8  per-requester operand, requester n at bits [8n+7:8n]
req_amt  input  NREQ*3  per-requester shift amount 0..7, requester n at [3n+2:3n]
req_rot  input  NREQ  per-requester mode: 1 = rotate right, 0 = logical right shift (zero fill)
req_ready  output  NREQ  one-hot-or-zero acceptance; a transfer on requester n = req_valid[n] & req_ready[n]
resp_valid  output  1  result register holds a valid result
resp_data  output  8  shifted result
resp_id  output  ID_W  index of the requester that produced resp_data
resp_ready  input  1  consumer accepts result when high with resp_valid
busy_cnt  output  16  saturating count of cycles with any req_valid high but no transfer (stall monitor)

Behaviour:
- Reset (rst=1 at clock edge) clears the following, and overrides any in-flight transfer or unaccepted result, which is discarded:
  - resp_valid=0, resp_data=0, resp_id=0, busy_cnt=0
  - rr_ptr=NREQ-1, so requester 0 has highest priority first
- While rst=1, req_ready is 0.
- Output register FSM has two states, EMPTY and FULL.
  - EMPTY -> FULL on a transfer.
  - FULL -> EMPTY on resp_ready with no new transfer.
  - FULL stays FULL on a resp_ready plus transfer in the same cycle, which is a back-to-back refill.
  - FULL stays FULL on no resp_ready, which holds the result.
- accept = (state==EMPTY) | resp_ready; combinational from state and resp_ready.
- Grant selection:
  - Search req_valid starting at index rr_ptr+1, wrapping modulo NREQ; the first set bit wins.
  - req_ready[win]=accept; all other req_ready bits are 0.
  - If no req_valid is set, req_ready=0.
- rr_ptr updates to the winner index only on an actual transfer; a stalled grant does not advance the pointer.
- Requesters hold valid and payload stable until ready. Changing the payload while stalled is legal; the value sampled at the transfer edge is the one used.
- Shift function:
  - rotate: out[k] = in[(k+amt) mod 8]
  - logical: out[k] = in[k+amt] if k+amt<8, else 0
  - amt=0 passes through unchanged.
- Latency: the result appears on resp_data/resp_id the cycle after the transfer, with resp_valid=1.
- Throughput: one result per cycle when resp_ready is held high.
- resp_data and resp_id are stable while resp_valid=1 and resp_ready=0.
- busy_cnt increments by 1 in any cycle where |req_valid=1 and no transfer occurs; it saturates at 16'hFFFF and does not wrap.
- A single requester asserting continuously with others idle is granted every accepting cycle.
- With all requesters valid and resp_ready=1, grants rotate 0,1,2,3,0,... one per cycle.

Decomposition:
- Shared package holds:
  - SHR_W=8, SHR_AMT_W=3
  - the mode encoding constants SHR_LOGICAL=0, SHR_ROTATE=1
- Sub-module shr8_core is a purely combinational 8-bit right shifter with three log stages (4,2,1), inputs data/amt/rot and output result. It is instantiated once, fed by the granted requester's muxed payload.
- Arbiter, output register FSM and busy counter live in the top module.

Test Plan:
- Reset then single request: req 0 sends 8'b00111111, amt=2, rot=0, resp_ready=1 -> ready same cycle; next cycle resp_valid=1, resp_data=8'b00001111, resp_id=0.
- Rotate cases on requester 2:
  - 8'b01100000, amt=4, rot=1 -> 8'b00000110
  - 8'b01000011, amt=1, rot=1 -> 8'b10100001
  - 8'b00001100, amt=6, rot=1 -> 8'b00110000
  - all return with resp_id=2.
- Fairness: all four valid continuously, resp_ready=1 -> resp_id sequence 0,1,2,3,0,1 on consecutive cycles; each req_ready high exactly once per 4 cycles.
- Backpressure: result FULL, resp_ready=0 for 3 cycles with req 1 valid -> req_ready=0, resp_data/resp_id unchanged, busy_cnt advances by 3. Then resp_ready=1 -> req 1 transferred the same cycle and its result appears the next cycle with no bubble.
- Reset mid-operation: rst=1 while FULL and requests pending -> next cycle resp_valid=0, busy_cnt=0, req_ready=0. After release, requester 0 wins over 3 when both are valid.
- Saturation: force 70000 stalled cycles -> busy_cnt holds 16'hFFFF.
